// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module      : mem_access_pkg
// Description : Op codes, FSM states, lane offsets and decode helpers for the
//               MIPS memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_t;

    // Big-endian: byte offset 0 is the most significant lane of the word.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic [1:0] LANE_H0 = 2'd0;
    localparam logic [1:0] LANE_H2 = 2'd2;

    function automatic size_t op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_unsigned(input logic [3:0] op);
        is_unsigned = (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'd0);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational big-endian lane extract/extend for loads and
//               lane merge for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (offset_i)
            LANE_B0: w_byte = word_i[31:24];
            LANE_B1: w_byte = word_i[23:16];
            LANE_B2: w_byte = word_i[15:8];
            LANE_B3: w_byte = word_i[7:0];
            default: w_byte = word_i[7:0];
        endcase

        w_half = word_i[31:16];
        case (offset_i)
            LANE_H0: w_half = word_i[31:16];
            LANE_H2: w_half = word_i[15:0];
            default: w_half = word_i[31:16];
        endcase
    end

    always_comb begin
        load_o = word_i;
        case (op_size(op_i))
            SZ_BYTE: load_o = is_unsigned(op_i) ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: load_o = is_unsigned(op_i) ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: load_o = word_i;
        endcase
    end

    // Only the addressed lane changes; the rest of the old word is kept.
    always_comb begin
        merge_o = word_i;
        case (op_size(op_i))
            SZ_BYTE: begin
                case (offset_i)
                    LANE_B0: merge_o[31:24] = wdata_i[7:0];
                    LANE_B1: merge_o[23:16] = wdata_i[7:0];
                    LANE_B2: merge_o[15:8]  = wdata_i[7:0];
                    LANE_B3: merge_o[7:0]   = wdata_i[7:0];
                    default: merge_o = word_i;
                endcase
            end
            SZ_HALF: begin
                case (offset_i)
                    LANE_H0: merge_o[31:16] = wdata_i;
                    LANE_H2: merge_o[15:0]  = wdata_i;
                    default: merge_o = word_i;
                endcase
            end
            default: merge_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding load/store initiator with sub-word
//               read-modify-write and alignment/illegal-op checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_err = (op_size(req_op) == SZ_NONE) || is_misaligned(req_op, req_addr[1:0]);

    mem_lane_align u_align (
        .op_i     (op_q),
        .offset_i (addr_q[1:0]),
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q[15:0]),
        .load_o   (w_load),
        .merge_o  (w_merge)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = w_err;
                    if (w_err)
                        state_d = ST_RESP;
                    else if (op_size(req_op) == SZ_WORD && is_store(req_op))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP: begin
                if (is_store(op_q)) begin
                    wdata_d = w_merge;
                    state_d = ST_WR;
                end else begin
                    rdata_d = w_load;
                    state_d = ST_RESP;
                end
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bits above ADDR_W are not decoded by the memory but still pass through.
    assign mem_addr   = {addr_q[31:ADDR_W], addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign mem_read   = (state_q == ST_RD);
    assign mem_write  = (state_q == ST_WR);
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = err_q & resp_valid;
    assign resp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with a
//               word-wide big-endian memory model (read data one cycle late).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int tests  = 0;
    int failed = 0;

    logic [31:0] mem [64];

    logic [31:0] o_rdata, o_waddr, o_wdata, o_raddr;
    logic        o_err, o_overlap, o_busy_ready;
    int          o_lat, o_nrd, o_nwr;

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:2]];
    end

    // Issues one request and records what the DUT did until resp_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_lat = -1; o_nrd = 0; o_nwr = 0; o_overlap = 1'b0; o_busy_ready = 1'b0;
        o_rdata = 32'hx; o_err = 1'bx; o_waddr = 32'hx; o_wdata = 32'hx; o_raddr = 32'hx;
        for (int k = 1; k <= 12; k++) begin
            if (mem_read && mem_write) o_overlap = 1'b1;
            if (mem_read)  begin o_nrd++; o_raddr = mem_addr; end
            if (mem_write) begin o_nwr++; o_waddr = mem_addr; o_wdata = mem_wdata; end
            if (req_ready) o_busy_ready = 1'b1;
            if (resp_valid) begin o_lat = k; o_rdata = resp_rdata; o_err = resp_err; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (req_ready !== 1'b1)   begin failed++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        tests++; if (resp_valid !== 1'b0)  begin failed++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        tests++; if (resp_err !== 1'b0)    begin failed++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        tests++; if (resp_rdata !== 32'd0) begin failed++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        tests++; if ({mem_read, mem_write} !== 2'b00) begin failed++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
        tests++; if (mem_addr !== 32'd0)   begin failed++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        tests++; if (mem_wdata !== 32'd0)  begin failed++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_word_roundtrip();
        run_op(4'b1011, 32'h10, 32'h8192A3B4);
        tests++; if (o_lat !== 2)     begin failed++; $display("FAIL sw_latency: got %0d expected 2", o_lat); end
        tests++; if (o_err !== 1'b0)  begin failed++; $display("FAIL sw_err: got %b expected 0", o_err); end
        tests++; if (o_nwr !== 1 || o_nrd !== 0) begin failed++; $display("FAIL sw_strobes: got rd=%0d wr=%0d expected rd=0 wr=1", o_nrd, o_nwr); end
        tests++; if (o_waddr !== 32'h10) begin failed++; $display("FAIL sw_addr: got %h expected 00000010", o_waddr); end
        tests++; if (o_wdata !== 32'h8192A3B4) begin failed++; $display("FAIL sw_wdata: got %h expected 8192a3b4", o_wdata); end
        tests++; if (o_busy_ready !== 1'b0) begin failed++; $display("FAIL sw_ready_busy: got %b expected 0", o_busy_ready); end
        run_op(4'b0011, 32'h10, 32'h0);
        tests++; if (o_lat !== 3)     begin failed++; $display("FAIL lw_latency: got %0d expected 3", o_lat); end
        tests++; if (o_rdata !== 32'h8192A3B4) begin failed++; $display("FAIL lw_rdata: got %h expected 8192a3b4", o_rdata); end
        tests++; if (o_nrd !== 1 || o_nwr !== 0) begin failed++; $display("FAIL lw_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", o_nrd, o_nwr); end
    endtask

    task automatic test_subword_loads();
        logic [3:0]  ops  [8] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0000, 4'b0001, 4'b0100, 4'b0000};
        logic [31:0] adrs [8] = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h13, 32'h10, 32'h10, 32'h12};
        logic [31:0] exps [8] = '{32'hFFFFFF92, 32'h00000092, 32'hFFFFA3B4, 32'h00008192,
                                  32'hFFFFFFB4, 32'hFFFF8192, 32'h00000081, 32'hFFFFFFA3};
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], adrs[i], 32'h0);
            tests++; if (o_rdata !== exps[i] || o_lat !== 3 || o_err !== 1'b0)
                begin failed++; $display("FAIL subword_load[%0d]: got %h lat %0d err %b expected %h lat 3 err 0", i, o_rdata, o_lat, o_err, exps[i]); end
        end
    endtask

    task automatic test_rmw();
        run_op(4'b1000, 32'h13, 32'h000000CC);
        tests++; if (o_lat !== 4) begin failed++; $display("FAIL sb_latency: got %0d expected 4", o_lat); end
        tests++; if (o_nrd !== 1 || o_nwr !== 1 || o_overlap !== 1'b0) begin failed++; $display("FAIL sb_strobes: got rd=%0d wr=%0d ovl=%b expected 1 1 0", o_nrd, o_nwr, o_overlap); end
        tests++; if (o_wdata !== 32'h8192A3CC) begin failed++; $display("FAIL sb_merge: got %h expected 8192a3cc", o_wdata); end
        tests++; if (o_rdata !== 32'd0) begin failed++; $display("FAIL sb_rdata: got %h expected 0", o_rdata); end
        run_op(4'b1001, 32'h10, 32'hABCD1234);
        tests++; if (o_wdata !== 32'h1234A3CC || o_waddr !== 32'h10) begin failed++; $display("FAIL sh_merge: got %h at %h expected 1234a3cc at 00000010", o_wdata, o_waddr); end
        run_op(4'b0011, 32'h10, 32'h0);
        tests++; if (o_rdata !== 32'h1234A3CC) begin failed++; $display("FAIL rmw_readback: got %h expected 1234a3cc", o_rdata); end
        run_op(4'b0011, 32'h00100010, 32'h0);
        tests++; if (o_rdata !== 32'h1234A3CC || o_raddr !== 32'h00100010) begin failed++; $display("FAIL addr_wrap: got %h at %h expected 1234a3cc at 00100010", o_rdata, o_raddr); end
    endtask

    task automatic test_errors();
        logic [3:0]  ops  [3] = '{4'b0011, 4'b1001, 4'b0010};
        logic [31:0] adrs [3] = '{32'h12, 32'h11, 32'h10};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], adrs[i], 32'hFFFFFFFF);
            tests++; if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'd0)
                begin failed++; $display("FAIL error[%0d]: got lat %0d err %b rdata %h expected lat 1 err 1 rdata 0", i, o_lat, o_err, o_rdata); end
            tests++; if (o_nrd !== 0 || o_nwr !== 0)
                begin failed++; $display("FAIL error_strobes[%0d]: got rd=%0d wr=%0d expected 0 0", i, o_nrd, o_nwr); end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int nwr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h10; req_wdata = 32'h000000EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++; if (mem_read !== 1'b1) begin failed++; $display("FAIL rst_rmw_rd: got %b expected 1", mem_read); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failed++; $display("FAIL rst_rmw_idle: got ready %b resp %b expected 1 0", req_ready, resp_valid); end
        for (int k = 0; k < 5; k++) begin
            if (mem_write) nwr++;
            @(posedge clk); #1;
        end
        tests++; if (nwr !== 0) begin failed++; $display("FAIL rst_rmw_write: got %0d writes expected 0", nwr); end
        run_op(4'b0011, 32'h10, 32'h0);
        tests++; if (o_rdata !== 32'h1234A3CC) begin failed++; $display("FAIL rst_rmw_unchanged: got %h expected 1234a3cc", o_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:1]  rdy, rv, mr, mw;
        logic        ovl = 1'b0;
        logic [31:0] first_rdata = 32'hx;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0011; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_op = 4'b1011; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
        for (int k = 1; k <= 7; k++) begin
            rdy[k] = req_ready; rv[k] = resp_valid; mr[k] = mem_read; mw[k] = mem_write;
            if (mem_read && mem_write) ovl = 1'b1;
            if (k == 3) first_rdata = resp_rdata;
            if (k == 5) req_valid = 1'b0;
            if (k < 7) begin @(posedge clk); #1; end
        end
        tests++; if (rdy !== 7'b1001000) begin failed++; $display("FAIL b2b_ready: got %b expected 1001000", rdy); end
        tests++; if (rv !== 7'b0100100)  begin failed++; $display("FAIL b2b_resp_valid: got %b expected 0100100", rv); end
        tests++; if (mr !== 7'b0000001 || mw !== 7'b0010000 || ovl !== 1'b0)
            begin failed++; $display("FAIL b2b_strobes: got rd %b wr %b ovl %b expected 0000001 0010000 0", mr, mw, ovl); end
        tests++; if (first_rdata !== 32'h1234A3CC) begin failed++; $display("FAIL b2b_lw_rdata: got %h expected 1234a3cc", first_rdata); end
        run_op(4'b0011, 32'h20, 32'h0);
        tests++; if (o_rdata !== 32'h0BADF00D) begin failed++; $display("FAIL b2b_sw_readback: got %h expected 0badf00d", o_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem_rdata = 32'd0;
        test_reset();
        test_word_roundtrip();
        test_subword_loads();
        test_rmw();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
